// File: rtl/uvw_pkg.sv
// Shared definitions for the uvw trace stages: violation codes, monitor
// state encoding and the sample counter width.
package uvw_pkg;

   localparam int unsigned COUNT_W = 16;

   localparam logic [1:0] VC_NONE = 2'd0;
   localparam logic [1:0] VC_SUM  = 2'd1;
   localparam logic [1:0] VC_VW   = 2'd2;
   localparam logic [1:0] VC_STEP = 2'd3;

   typedef enum logic [1:0] {
      EMPTY_HIST = 2'd0,
      TRACK      = 2'd1,
      FAULT      = 2'd2
   } mon_state_e;

   // Highest-priority failing check wins: SUM > VW > STEP.
   function automatic logic [1:0] vc_encode(input logic sum_f, input logic vw_f, input logic step_f);
      if (sum_f) begin
         return VC_SUM;
      end else if (vw_f) begin
         return VC_VW;
      end else if (step_f) begin
         return VC_STEP;
      end
      return VC_NONE;
   endfunction

endpackage

// File: rtl/uvw_fifo.sv
// Parameterised synchronous FIFO with registered-pointer head output.
// UVW_MON_ASSERT_EN adds an occupancy-bound assertion.
module uvw_fifo #(
   parameter int unsigned DW    = 10,
   parameter int unsigned DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   output logic          full,
   input  logic          rd_en,
   output logic [DW-1:0] rd_data,
   output logic          empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;
   logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]            count_q, count_d;
   logic                     push, pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign push    = wr_en && !full;
   assign pop     = rd_en && !empty;
   assign rd_data = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage is cleared on reset so the head reads zero until the first push.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

`ifdef UVW_MON_ASSERT_EN
   always_comb begin
      prop_occupancy: assert (count_q <= CW'(DEPTH));
   end
`endif

endmodule

// File: rtl/uvw_trace_monitor.sv
// Checks each accepted (u,v,w) triple, buffers it with its verdict and keeps
// a sticky first-violation record. UVW_MON_ASSERT_EN enables prop_trace.
module uvw_trace_monitor
   import uvw_pkg::*;
#(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_u,
   input  logic [WIDTH-1:0]   in_v,
   input  logic [WIDTH-1:0]   in_w,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_u,
   output logic [WIDTH-1:0]   out_v,
   output logic [WIDTH-1:0]   out_w,
   output logic               out_fail,
   output logic               viol,
   output logic [1:0]         viol_code,
   output logic [COUNT_W-1:0] sample_count
);

   localparam int unsigned DW = 3 * WIDTH + 1;

   logic               full, empty, push;
   logic               sum_fail, vw_fail, step_fail, any_fail;
   logic [WIDTH-1:0]   uv_sum, next_v;
   logic [DW-1:0]      wr_data, rd_data;

   mon_state_e         state_q, state_d;
   logic [WIDTH-1:0]   prev_v_q, prev_v_d;
   logic               viol_q, viol_d;
   logic [1:0]         viol_code_q, viol_code_d;
   logic [COUNT_W-1:0] count_q, count_d;

   assign in_ready = !full;
   assign push     = in_valid && !full;

   assign uv_sum    = in_u + in_v;
   assign next_v    = prev_v_q + 1'b1;
   assign sum_fail  = (uv_sum == WIDTH'(1));
   assign vw_fail   = (in_v != in_w);
   assign step_fail = (state_q != EMPTY_HIST) && (in_v != next_v);
   assign any_fail  = sum_fail || vw_fail || step_fail;

   assign wr_data = {any_fail, in_u, in_v, in_w};

   uvw_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (in_valid),
      .wr_data (wr_data),
      .full    (full),
      .rd_en   (out_ready),
      .rd_data (rd_data),
      .empty   (empty)
   );

   assign out_valid                     = !empty;
   assign {out_fail, out_u, out_v, out_w} = rd_data;

   always_comb begin
      state_d     = state_q;
      prev_v_d    = prev_v_q;
      viol_d      = viol_q;
      viol_code_d = viol_code_q;
      count_d     = count_q;
      if (push) begin
         prev_v_d = in_v;
         if (count_q != '1) begin
            count_d = count_q + 1'b1;
         end
         // A failing first sample goes straight to FAULT so the flag still latches.
         unique case (state_q)
            EMPTY_HIST: state_d = any_fail ? FAULT : TRACK;
            TRACK:      state_d = any_fail ? FAULT : TRACK;
            default:    state_d = FAULT;
         endcase
         if (any_fail && (state_q != FAULT)) begin
            viol_d      = 1'b1;
            viol_code_d = vc_encode(sum_fail, vw_fail, step_fail);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EMPTY_HIST;
         prev_v_q    <= '0;
         viol_q      <= 1'b0;
         viol_code_q <= VC_NONE;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         prev_v_q    <= prev_v_d;
         viol_q      <= viol_d;
         viol_code_q <= viol_code_d;
         count_q     <= count_d;
      end
   end

   assign viol         = viol_q;
   assign viol_code    = viol_code_q;
   assign sample_count = count_q;

`ifdef UVW_MON_ASSERT_EN
   always_comb begin
      prop_trace: assert (!viol_q);
   end
`endif

endmodule
